// File: rtl/sccb_responder.sv
// SCCB write responder with synchronized bus sampling and auto-incrementing register address.
// Define SCCB_READ_EN to also answer DEV_ADDR|1 and return reg_rdata.
module sccb_responder #(
  parameter logic [7:0] DEV_ADDR = 8'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE
  } state_t;

  state_t     state;
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic [3:0] cnt;
  logic [7:0] sh;

  logic scl, scl_d, sda, sda_d;
  logic rise, fall, start, stop;
  logic [7:0] byte_in;
  logic rd_ok;

  assign scl   = scl_q[1];
  assign scl_d = scl_q[2];
  assign sda   = sda_q[1];
  assign sda_d = sda_q[2];

  assign rise  = scl & ~scl_d;
  assign fall  = ~scl & scl_d;
  assign start = scl & scl_d & sda_d & ~sda;
  assign stop  = scl & scl_d & ~sda_d & sda;

  assign byte_in = {sh[6:0], sda};

`ifdef SCCB_READ_EN
  assign rd_ok = (byte_in == (DEV_ADDR | 8'h01));
`else
  logic [7:0] unused_rdata;
  assign unused_rdata = reg_rdata;
  assign rd_ok = 1'b0;
`endif

  // Two sync flops plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], sioc};
      sda_q <= {sda_q[1:0], siod_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      siod_oe   <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      sh        <= 8'h00;
    end else begin
      reg_we <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        siod_oe <= 1'b0;
        busy    <= 1'b0;
        cnt     <= 4'd0;
      end else if (start) begin
        state   <= DEV;
        siod_oe <= 1'b0;
        busy    <= 1'b1;
        cnt     <= 4'd0;
      end else begin
        unique case (state)
          DEV: if (rise) begin
            sh  <= byte_in;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7)
              state <= (byte_in == DEV_ADDR || rd_ok)
                       ? DEV_ACK : IGNORE;
          end
          REG: if (rise) begin
            sh  <= byte_in;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              reg_addr <= byte_in;
              state    <= REG_ACK;
            end
          end
          WDATA: if (rise) begin
            sh  <= byte_in;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              reg_wdata <= byte_in;
              reg_we    <= 1'b1;
              state     <= WDATA_ACK;
            end
          end
          // First falling edge pulls the ACK, second one releases it.
          DEV_ACK: if (fall) begin
            if (!siod_oe) begin
              siod_oe <= 1'b1;
            end else begin
              cnt <= 4'd0;
`ifdef SCCB_READ_EN
              if (sh[0]) begin
                sh      <= reg_rdata;
                siod_oe <= ~reg_rdata[7];
                state   <= RDATA;
              end else begin
                siod_oe <= 1'b0;
                state   <= REG;
              end
`else
              siod_oe <= 1'b0;
              state   <= REG;
`endif
            end
          end
          REG_ACK: if (fall) begin
            if (!siod_oe) begin
              siod_oe <= 1'b1;
            end else begin
              siod_oe <= 1'b0;
              cnt     <= 4'd0;
              state   <= WDATA;
            end
          end
          WDATA_ACK: if (fall) begin
            if (!siod_oe) begin
              siod_oe <= 1'b1;
            end else begin
              siod_oe  <= 1'b0;
              cnt      <= 4'd0;
              reg_addr <= reg_addr + 8'd1;
              state    <= WDATA;
            end
          end
`ifdef SCCB_READ_EN
          RDATA: begin
            if (rise) cnt <= cnt + 4'd1;
            if (fall) begin
              if (cnt == 4'd8) begin
                siod_oe <= 1'b0;
                state   <= RD_NA;
              end else begin
                sh      <= {sh[6:0], 1'b0};
                siod_oe <= ~sh[6];
              end
            end
          end
          RD_NA: begin
            if (rise) begin
              if (sda) state    <= IGNORE;
              else     reg_addr <= reg_addr + 8'd1;
            end else if (fall) begin
              sh      <= reg_rdata;
              siod_oe <= ~reg_rdata[7];
              cnt     <= 4'd0;
              state   <= RDATA;
            end
          end
`endif
          IDLE, IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: 25 MHz clk, 100 kHz SCCB master model.
`timescale 1ns/1ps
module tb_sccb_responder;

  localparam int Q = 2500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       siod_in;
  logic       siod_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         we_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] we_addr [32];
  logic [7:0] we_data [32];

  always #20 clk = ~clk;

  assign siod_in = sda_m & ~siod_oe;

  sccb_responder #(.DEV_ADDR(8'h42)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sioc(scl_m),
    .siod_in(siod_in),
    .siod_oe(siod_oe),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_rdata(reg_rdata),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr[we_cnt[4:0]] <= reg_addr;
      we_data[we_cnt[4:0]] <= reg_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (siod_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    b = siod_in; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic a);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(b);
    a = ~b;
  endtask

  logic       ack;
  logic [7:0] rb;
  int         n0, o0;

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    reg_rdata = 8'hA5;
    #200;
    check("rst_oe", siod_oe, 0);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_we", reg_we, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #400;

    // basic write 42/12/80
    n0 = we_cnt;
    bus_start();
    check("t1_busy", busy, 1);
    send_byte(8'h42, ack); check("t1_ack_dev", ack, 1);
    send_byte(8'h12, ack); check("t1_ack_reg", ack, 1);
    send_byte(8'h80, ack); check("t1_ack_dat", ack, 1);
    bus_stop();
    check("t1_busy_off", busy, 0);
    check("t1_we_n", we_cnt - n0, 1);
    check("t1_we_addr", we_addr[n0], 8'h12);
    check("t1_we_data", we_data[n0], 8'h80);
    check("t1_addr_inc", reg_addr, 8'h13);

    // foreign device address
    n0 = we_cnt; o0 = oe_cnt;
    bus_start();
    send_byte(8'h44, ack); check("t2_nack", ack, 0);
    send_byte(8'h55, ack);
    bus_stop();
    check("t2_we_n", we_cnt - n0, 0);
    check("t2_oe_n", oe_cnt - o0, 0);
    check("t2_busy", busy, 0);

    // address wrap
    n0 = we_cnt;
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack); check("t3_ack1", ack, 1);
    send_byte(8'h22, ack); check("t3_ack2", ack, 1);
    bus_stop();
    check("t3_we_n", we_cnt - n0, 2);
    check("t3_addr0", we_addr[n0], 8'hFF);
    check("t3_data0", we_data[n0], 8'h11);
    check("t3_addr1", we_addr[n0+1], 8'h00);
    check("t3_data1", we_data[n0+1], 8'h22);
    check("t3_addr", reg_addr, 8'h01);

    // stop after 5 data bits
    n0 = we_cnt;
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h30, ack);
    bit_out(1); bit_out(0); bit_out(1); bit_out(0); bit_out(1);
    bus_stop();
    check("t4_we_n", we_cnt - n0, 0);
    check("t4_wdata", reg_wdata, 8'h22);
    check("t4_addr", reg_addr, 8'h30);
    check("t4_busy", busy, 0);
    n0 = we_cnt;
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h31, ack);
    send_byte(8'h5C, ack); check("t4b_ack", ack, 1);
    bus_stop();
    check("t4b_we_n", we_cnt - n0, 1);
    check("t4b_addr", we_addr[n0], 8'h31);
    check("t4b_data", we_data[n0], 8'h5C);

    // repeated start discards partial byte
    n0 = we_cnt;
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h20, ack);
    bit_out(0); bit_out(1); bit_out(1);
    bus_start();
    send_byte(8'h42, ack); check("t5_ack_dev", ack, 1);
    send_byte(8'h21, ack);
    send_byte(8'h66, ack);
    bus_stop();
    check("t5_we_n", we_cnt - n0, 1);
    check("t5_addr", we_addr[n0], 8'h21);
    check("t5_data", we_data[n0], 8'h66);

    // reset during DEV ACK slot
    bus_start();
    for (int i = 7; i >= 0; i--) bit_out(1'(8'h42 >> i));
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    check("t6_oe_pre", siod_oe, 1);
    rst_n = 1'b0;
    #1;
    check("t6_oe_rst", siod_oe, 0);
    check("t6_busy_rst", busy, 0);
    #Q; scl_m = 1'b0; #Q;
    rst_n = 1'b1; #Q;
    bus_stop();
    check("t6_addr_rst", reg_addr, 8'h00);
    n0 = we_cnt;
    bus_start();
    send_byte(8'h42, ack); check("t6_ack_dev", ack, 1);
    send_byte(8'h05, ack); check("t6_ack_reg", ack, 1);
    send_byte(8'h77, ack); check("t6_ack_dat", ack, 1);
    bus_stop();
    check("t6_we_n", we_cnt - n0, 1);
    check("t6_addr", we_addr[n0], 8'h05);
    check("t6_data", we_data[n0], 8'h77);

`ifdef SCCB_READ_EN
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h3A, ack);
    bus_stop();
    bus_start();
    send_byte(8'h43, ack); check("rd_ack", ack, 1);
    for (int i = 7; i >= 0; i--) begin
      logic b;
      bit_in(b);
      rb[i] = b;
    end
    bit_out(1'b1);
    bus_stop();
    check("rd_data", rb, 8'hA5);
    check("rd_busy", busy, 0);
    check("rd_oe", siod_oe, 0);
`else
    rb = 8'h00;
    bus_start();
    send_byte(8'h43, ack); check("rd_nack", ack, 0);
    bus_stop();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
